// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants, state encoding and table helpers for the UART command responder
package uart_pkg;

  localparam int BYTE_W = 8;
  localparam logic [BYTE_W-1:0] NAK_BYTE_DEF = 8'h3F;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_MATCH     = 3'd1;
  localparam state_t ST_LOAD      = 3'd2;
  localparam state_t ST_WAIT_ACK  = 3'd3;
  localparam state_t ST_WAIT_DONE = 3'd4;
  localparam state_t ST_GAP       = 3'd5;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Reply strings are written as literals, so the first character sent is the
  // most significant byte of each entry.
  function automatic int resp_offset(input int cmd, input int pos, input int msg_len);
    return (cmd * msg_len + (msg_len - 1 - pos)) * BYTE_W;
  endfunction

endpackage

// File: rtl/uart_resp_rom.sv
// rtl/uart_resp_rom.sv - combinational (command index, byte index) -> reply byte lookup
module uart_resp_rom
  import uart_pkg::*;
#(
  parameter int NUM_CMDS = 2,
  parameter int MSG_LEN = 4,
  parameter logic [NUM_CMDS*MSG_LEN*BYTE_W-1:0] RESP_TABLE = '0,
  localparam int CMD_W = idx_width(NUM_CMDS),
  localparam int IDX_W = idx_width(MSG_LEN)
) (
  input  logic [CMD_W-1:0]  cmd_idx,
  input  logic [IDX_W-1:0]  byte_idx,
  output logic [BYTE_W-1:0] data
);

  always_comb begin
    data = '0;
    for (int c = 0; c < NUM_CMDS; c++) begin
      for (int p = 0; p < MSG_LEN; p++) begin
        if (cmd_idx == CMD_W'(c) && byte_idx == IDX_W'(p)) begin
          data = RESP_TABLE[resp_offset(c, p, MSG_LEN) +: BYTE_W];
        end
      end
    end
  end

endmodule

// File: rtl/uart_cmd_responder.sv
// rtl/uart_cmd_responder.sv - matches received command bytes and streams the table reply to uart_tx
module uart_cmd_responder
  import uart_pkg::*;
#(
  parameter int NUM_CMDS = 2,
  parameter int MSG_LEN = 4,
  parameter logic [NUM_CMDS*BYTE_W-1:0] CMD_CODES = {8'h32, 8'h31},
  parameter logic [NUM_CMDS*MSG_LEN*BYTE_W-1:0] RESP_TABLE = {"PLAC", "CCNU"},
  parameter bit NAK_EN = 1'b1,
  parameter logic [BYTE_W-1:0] NAK_BYTE = NAK_BYTE_DEF,
  parameter int GAP_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       busy,
  output logic       resp_done,
  output logic       cmd_err,
  output logic [7:0] drop_cnt
);

  localparam int CMD_W = idx_width(NUM_CMDS);
  localparam int IDX_W = idx_width(MSG_LEN);
  localparam int GAP_W = idx_width(GAP_CYCLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_LEN - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t             state;
  logic [BYTE_W-1:0]  cmd_byte;
  logic [CMD_W-1:0]   cmd_idx;
  logic [IDX_W-1:0]   byte_idx;
  logic               nak_mode;
  logic [GAP_W-1:0]   gap_cnt;

  logic               hit;
  logic [CMD_W-1:0]   hit_idx;
  logic [CMD_W-1:0]   rom_cmd;
  logic [IDX_W-1:0]   rom_pos;
  logic [BYTE_W-1:0]  rom_data;
  logic               last_byte;

  // Descending scan so the lowest matching index overrides duplicates.
  always_comb begin
    hit = 1'b0;
    hit_idx = '0;
    for (int i = NUM_CMDS - 1; i >= 0; i--) begin
      if (cmd_byte == CMD_CODES[i*BYTE_W +: BYTE_W]) begin
        hit = 1'b1;
        hit_idx = CMD_W'(i);
      end
    end
  end

  // The ROM is addressed with the byte about to be loaded, so tx_data is
  // already valid in the LOAD cycle that raises tx_start.
  always_comb begin
    rom_cmd = cmd_idx;
    rom_pos = byte_idx;
    if (state == ST_MATCH) begin
      rom_cmd = hit_idx;
      rom_pos = '0;
    end else if (state == ST_WAIT_DONE) begin
      rom_pos = byte_idx + IDX_W'(1);
    end
  end

  uart_resp_rom #(
    .NUM_CMDS   (NUM_CMDS),
    .MSG_LEN    (MSG_LEN),
    .RESP_TABLE (RESP_TABLE)
  ) u_rom (
    .cmd_idx  (rom_cmd),
    .byte_idx (rom_pos),
    .data     (rom_data)
  );

  assign last_byte = nak_mode || (byte_idx == LAST_IDX);
  assign tx_start  = (state == ST_LOAD) && !tx_busy;
  assign busy      = (state != ST_IDLE);
  assign resp_done = (state == ST_WAIT_DONE) && !tx_busy && last_byte;
  assign cmd_err   = (state == ST_MATCH) && !hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cmd_byte <= '0;
      cmd_idx  <= '0;
      byte_idx <= '0;
      nak_mode <= 1'b0;
      gap_cnt  <= '0;
      tx_data  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rx_valid) begin
            cmd_byte <= rx_data;
            state    <= ST_MATCH;
          end
        end
        ST_MATCH: begin
          byte_idx <= '0;
          if (hit) begin
            cmd_idx  <= hit_idx;
            nak_mode <= 1'b0;
            tx_data  <= rom_data;
            state    <= ST_LOAD;
          end else if (NAK_EN) begin
            nak_mode <= 1'b1;
            tx_data  <= NAK_BYTE;
            state    <= ST_LOAD;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_LOAD: begin
          if (!tx_busy) state <= ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          if (tx_busy) state <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (!tx_busy) begin
            if (last_byte) begin
              state <= ST_IDLE;
            end else begin
              byte_idx <= byte_idx + IDX_W'(1);
              if (GAP_CYCLES == 0) begin
                tx_data <= rom_data;
                state   <= ST_LOAD;
              end else begin
                gap_cnt <= '0;
                state   <= ST_GAP;
              end
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            tx_data <= rom_data;
            state   <= ST_LOAD;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (rx_valid && state != ST_IDLE && drop_cnt != 8'hFF) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_uart_cmd_responder.sv
// tb/tb_uart_cmd_responder.sv - scoreboard bench for uart_cmd_responder against a string-table reply model
module tb_uart_cmd_responder;

  localparam int GAP = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       rx_valid, rx_valid0;
  logic [7:0] rx_data, rx_data0;
  logic       tx_busy, tx_busy0;
  logic       tx_start, tx_start0;
  logic [7:0] tx_data, tx_data0;
  logic       busy, busy0;
  logic       resp_done, resp_done0;
  logic       cmd_err, cmd_err0;
  logic [7:0] drop_cnt, drop_cnt0;

  uart_cmd_responder #(
    .NUM_CMDS(2), .MSG_LEN(4), .CMD_CODES({8'h32, 8'h31}),
    .RESP_TABLE({"PLAC", "CCNU"}), .NAK_EN(1'b1), .NAK_BYTE(8'h3F), .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data), .busy(busy),
    .resp_done(resp_done), .cmd_err(cmd_err), .drop_cnt(drop_cnt)
  );

  uart_cmd_responder #(
    .NUM_CMDS(2), .MSG_LEN(4), .CMD_CODES({8'h32, 8'h31}),
    .RESP_TABLE({"PLAC", "CCNU"}), .NAK_EN(1'b0), .NAK_BYTE(8'h3F), .GAP_CYCLES(0)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid0), .rx_data(rx_data0),
    .tx_busy(tx_busy0), .tx_start(tx_start0), .tx_data(tx_data0), .busy(busy0),
    .resp_done(resp_done0), .cmd_err(cmd_err0), .drop_cnt(drop_cnt0)
  );

  // Transmitter models: busy from the cycle after tx_start for busy_len cycles.
  int   busy_len;
  logic hold_busy;
  int   busy_cnt, busy0_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_cnt <= 0;
    else if (tx_start) busy_cnt <= busy_len;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt > 0) || hold_busy;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy0_cnt <= 0;
    else if (tx_start0) busy0_cnt <= 3;
    else if (busy0_cnt > 0) busy0_cnt <= busy0_cnt - 1;
  end
  assign tx_busy0 = (busy0_cnt > 0);

  int n_pass = 0, n_total = 0;
  int cyc = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp0_q[$];
  int n_start = 0, n_resp = 0, n_err = 0;
  int n_start0 = 0, n_resp0 = 0, n_err0 = 0;
  int lat_cyc = 0;
  bit lat_pend = 0;
  int last_start = 0, reply_pos = 0;
  int exp_drop = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: a command maps to its reply string, anything else to "?".
  task automatic model_push(input logic [7:0] c, input bit nak_en, output bit is_err,
                            inout logic [7:0] q[$]);
    string s;
    is_err = 1'b0;
    if (c == 8'h31) s = "CCNU";
    else if (c == 8'h32) s = "PLAC";
    else begin
      is_err = 1'b1;
      s = nak_en ? "?" : "";
    end
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      reply_pos = 0;
      lat_pend = 0;
    end else begin
      if (tx_start) begin
        n_start++;
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL tx_unexpected: got byte %0h expected no tx_start", tx_data);
        end else check("tx_byte", tx_data, exp_q.pop_front());
        if (lat_pend) begin
          check("rx_to_tx_latency", cyc - lat_cyc, 2);
          lat_pend = 0;
        end
        if (reply_pos > 0) check("byte_spacing_ok", (cyc - last_start) >= busy_len + GAP, 1);
        last_start = cyc;
        reply_pos++;
      end
      if (resp_done) begin
        n_resp++;
        reply_pos = 0;
      end
      if (cmd_err) n_err++;
      if (tx_start0) begin
        n_start0++;
        if (exp0_q.size() == 0) begin
          n_total++;
          $display("FAIL tx0_unexpected: got byte %0h expected no tx_start", tx_data0);
        end else check("tx0_byte", tx_data0, exp0_q.pop_front());
      end
      if (resp_done0) n_resp0++;
      if (cmd_err0) n_err0++;
    end
  end

  task automatic wait_idle(input int budget);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while ((busy || exp_q.size() != 0) && k < budget);
    check("reply_complete_bytes_left", exp_q.size(), 0);
    check("idle_after_reply", busy, 1'b0);
    exp_q.delete();
  endtask

  task automatic send(input logic [7:0] c, input bit chk_lat);
    @(posedge clk); #1;
    rx_data = c;
    rx_valid = 1'b1;
    if (chk_lat) begin
      lat_cyc = cyc;
      lat_pend = 1'b1;
    end
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic run_cmd(input logic [7:0] c, input bit chk_lat);
    int r0, e0;
    bit e;
    r0 = n_resp;
    e0 = n_err;
    model_push(c, 1'b1, e, exp_q);
    send(c, chk_lat);
    wait_idle(3000);
    check("resp_done_count", n_resp - r0, 1);
    check("cmd_err_count", n_err - e0, e);
  endtask

  task automatic pulse_rx0(input logic [7:0] c);
    @(posedge clk); #1;
    rx_data0 = c;
    rx_valid0 = 1'b1;
    @(posedge clk); #1;
    rx_valid0 = 1'b0;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, s1, e0, r0, k;
    bit e;
    logic [7:0] c;

    rst_n = 1'b0;
    rx_valid = 1'b0; rx_data = '0;
    rx_valid0 = 1'b0; rx_data0 = '0;
    hold_busy = 1'b0;
    busy_len = 100;
    repeat (3) @(posedge clk);
    #1;
    check("reset_tx_start", tx_start, 1'b0);
    check("reset_tx_data", tx_data, 8'h00);
    check("reset_busy", busy, 1'b0);
    check("reset_resp_done", resp_done, 1'b0);
    check("reset_cmd_err", cmd_err, 1'b0);
    check("reset_drop_cnt", drop_cnt, 8'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    run_cmd(8'h31, 1'b1);
    run_cmd(8'h32, 1'b1);
    run_cmd(8'h35, 1'b1);

    // NAK disabled, zero gap: unknown byte errors out with no transmit.
    s0 = n_start0; e0 = n_err0; r0 = n_resp0;
    pulse_rx0(8'h35);
    @(negedge clk);
    check("nak_off_busy_in_match", busy0, 1'b1);
    check("nak_off_cmd_err", cmd_err0, 1'b1);
    @(posedge clk); #1;
    check("nak_off_busy_low", busy0, 1'b0);
    repeat (20) @(posedge clk);
    check("nak_off_no_tx", n_start0 - s0, 0);
    check("nak_off_err_count", n_err0 - e0, 1);
    check("nak_off_no_resp", n_resp0 - r0, 0);
    s0 = n_start0; r0 = n_resp0;
    model_push(8'h31, 1'b0, e, exp0_q);
    pulse_rx0(8'h31);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while ((busy0 || exp0_q.size() != 0) && k < 500);
    check("gap0_bytes_left", exp0_q.size(), 0);
    check("gap0_start_count", n_start0 - s0, 4);
    check("gap0_resp_count", n_resp0 - r0, 1);
    exp0_q.delete();

    // Drops while a reply is in flight.
    model_push(8'h31, 1'b1, e, exp_q);
    send(8'h31, 1'b0);
    for (int i = 0; i < 3; i++) begin
      repeat (120) @(posedge clk);
      #1;
      check("busy_during_drop", busy, 1'b1);
      rx_data = 8'($urandom);
      rx_valid = 1'b1;
      exp_drop = exp_drop + 1;
      @(posedge clk); #1;
      rx_valid = 1'b0;
    end
    wait_idle(3000);
    check("drop_cnt_three", drop_cnt, exp_drop);

    model_push(8'h31, 1'b1, e, exp_q);
    send(8'h31, 1'b0);
    @(posedge clk); #1;
    rx_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      rx_data = 8'($urandom);
      @(posedge clk); #1;
    end
    rx_valid = 1'b0;
    exp_drop = (exp_drop + 300 > 255) ? 255 : exp_drop + 300;
    wait_idle(3000);
    check("drop_cnt_saturated", drop_cnt, exp_drop);

    // Transmitter already busy when LOAD is reached.
    busy_len = 5;
    hold_busy = 1'b1;
    model_push(8'h32, 1'b1, e, exp_q);
    s0 = n_start;
    send(8'h32, 1'b0);
    repeat (20) @(negedge clk);
    check("start_withheld", n_start - s0, 0);
    check("busy_while_withheld", busy, 1'b1);
    @(posedge clk); #1;
    hold_busy = 1'b0;
    wait_idle(3000);
    check("start_count_after_hold", n_start - s0, 4);

    // Asynchronous reset in the gap after the second byte.
    busy_len = 30;
    model_push(8'h31, 1'b1, e, exp_q);
    s0 = n_start;
    send(8'h31, 1'b0);
    k = 0;
    while (n_start - s0 < 2 && k < 1000) begin
      @(negedge clk);
      k++;
    end
    check("reset_test_two_bytes_sent", n_start - s0, 2);
    repeat (busy_len + 5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_tx_start", tx_start, 1'b0);
    check("async_rst_tx_data", tx_data, 8'h00);
    check("async_rst_drop_cnt", drop_cnt, 8'd0);
    exp_q.delete();
    exp_drop = 0;
    s1 = n_start;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("no_tx_after_abort", n_start - s1, 0);
    run_cmd(8'h32, 1'b1);

    for (int i = 0; i < 8; i++) begin
      busy_len = $urandom_range(1, 40);
      case ($urandom_range(0, 2))
        0: c = 8'h31;
        1: c = 8'h32;
        default: c = 8'($urandom);
      endcase
      run_cmd(c, 1'b1);
    end

    check("final_drop_cnt", drop_cnt, exp_drop);
    check("dut0_drop_cnt", drop_cnt0, 8'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
